map_bbox_scan: RTL and testbench
================================

Name: map_bbox_scan

Overview:
- Consumer at the far end of the binary-map handshake (dmn_en / dmn_end, addra_dmn / douta_dmn).
- Requests thresholding and waits until the map is released. Then raster-scans the 1-bit map and reports the bounding box and pixel count of all set (dark-line) pixels.
- Finally releases the handshake, so downstream coordinate/QR-locating logic gets one result per frame.

Parameters:
- MAP_AW, 16, binary-map address width (addra_dmn width).
- CW, 16, coordinate/result width for x/y outputs.
- RD_LAT, 2, cycles from addra_dmn change to valid douta_dmn (1..7).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to process a frame; ignored unless idle.
- width  in  32  image width in pixels (sampled at start).
- height  in  32  image height in pixels (sampled at start).
- dmn_en  out  1  request to thresholding block; held high from REQ until REL.
- dmn_end  in  1  thresholding block indicates binary map valid and readable.
- addra_dmn  out  MAP_AW  binary-map read address = y*width + x.
- douta_dmn  in  1  binary-map read data (1 = line pixel).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when results are updated.
- err  out  1  sticky per-frame error, valid with done.
- found  out  1  at least one set pixel in the last frame.
- x_min, x_max, y_min, y_max  out  CW each  bounding box of set pixels, inclusive.
- pix_cnt  out  MAP_AW+1  number of set pixels.

Behaviour:
- Reset (async, rst=1): state IDLE; dmn_en, busy, done, err, found = 0; addra_dmn = 0; x/y outputs = 0; pix_cnt = 0; pipeline valids cleared. Reset mid-frame aborts immediately; dmn_en drops at once.
- States: IDLE, REQ, SCAN, DRAIN, REL, DONE.
- IDLE:
  - On start, latch width/height and compute total = width*height (64-bit).
  - If width==0, height==0 or total > 2^MAP_AW, set err=1 and go to DONE; no handshake, found=0.
  - Otherwise go to REQ.
- REQ: dmn_en=1; wait for dmn_end=1, then go to SCAN with x=0, y=0, addra_dmn=0.
- SCAN:
  - One address per cycle: addra_dmn increments by 1; x increments and wraps to 0 at width-1, with y+1.
  - Each issued (x,y) enters an RD_LAT-deep tag pipeline with a valid bit.
  - After issuing address total-1, go to DRAIN.
- DRAIN: wait RD_LAT cycles until the pipeline is empty, then go to REL.
- Accumulate, for each valid pipeline output with douta_dmn=1:
  - pix_cnt_acc++;
  - update min/max x/y running registers.
  - Init values: min = all ones, max = 0, flag found_acc.
- Abort: dmn_end falling during SCAN or DRAIN sets err=1, discards the pipeline, and goes to REL.
- REL: dmn_en=0; wait for dmn_end=0, then go to DONE.
- DONE, one cycle:
  - Copy accumulators to outputs; done=1; go to IDLE.
  - If found_acc=0, x/y outputs = 0.
- Outputs hold between frames. start during busy is ignored; start in the same cycle as DONE is ignored.
- Latency: the first address is issued the cycle after dmn_end is seen. Total SCAN+DRAIN = total + RD_LAT cycles.
- Coordinates truncate to CW bits; the MAP_AW limit guarantees no overflow for defaults.

Test Plan:
- 4x3 map, only addr 5 set, RD_LAT=2 -> done, found=1, x_min=x_max=1, y_min=y_max=1, pix_cnt=1, err=0; 12 consecutive addresses 0..11.
- 8x8 map, set pixels at (2,1), (6,1), (3,7) -> x_min=2, x_max=6, y_min=1, y_max=7, pix_cnt=3.
- All-zero 5x5 map -> found=0, pix_cnt=0, all coords 0, dmn_en high only between REQ and REL.
- width=0 or width=300,height=300 (>65536) -> err=1, done within 2 cycles of start, dmn_en never asserted.
- dmn_end forced low mid-SCAN -> err=1, dmn_en falls next cycle, done after dmn_end low; a following clean frame gives correct results and err=0.
- rst pulsed during SCAN -> all outputs 0 asynchronously; start pulse during busy produces no second done.

Source files
------------

// File: rtl/map_bbox_scan_if.sv
// Binary-map read handshake between the thresholding block (slave) and the
// bounding-box scanner (master).
interface map_bbox_scan_if #(
  parameter int MAP_AW = 16
);
  logic              dmn_en;
  logic              dmn_end;
  logic [MAP_AW-1:0] addra_dmn;
  logic              douta_dmn;

  modport master (
    output dmn_en,
    output addra_dmn,
    input  dmn_end,
    input  douta_dmn
  );

  modport slave (
    input  dmn_en,
    input  addra_dmn,
    output dmn_end,
    output douta_dmn
  );
endinterface

// File: rtl/map_bbox_scan.sv
// Raster-scans the 1-bit binary map once per frame and reports the bounding
// box and count of set pixels, owning the dmn_en/dmn_end handshake.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// REQ    | dmn_en high, waiting for map valid (dmn_end)
// SCAN   | issuing one map address per cycle
// DRAIN  | waiting for the last RD_LAT reads to return
// REL    | dmn_en low, waiting for dmn_end to drop
// DONE   | publish accumulators, pulse done
module map_bbox_scan #(
  parameter int MAP_AW = 16,
  parameter int CW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       width,
  input  logic [31:0]       height,
  map_bbox_scan_if.master   map,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              found,
  output logic [CW-1:0]     x_min,
  output logic [CW-1:0]     x_max,
  output logic [CW-1:0]     y_min,
  output logic [CW-1:0]     y_max,
  output logic [MAP_AW:0]   pix_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic              en_r;
  logic [31:0]       w_reg;
  logic [MAP_AW-1:0] addr;
  logic [MAP_AW-1:0] last_addr;
  logic [MAP_AW-1:0] xc;
  logic [MAP_AW-1:0] yc;
  logic [2:0]        drain_cnt;
  logic              err_acc;

  logic [63:0]       total;
  logic              bad;
  logic              active;
  logic              abort;
  logic              hit;

  logic              pv [RD_LAT];
  logic [CW-1:0]     px [RD_LAT];
  logic [CW-1:0]     py [RD_LAT];

  logic              found_acc;
  logic [MAP_AW:0]   pix_acc;
  logic [CW-1:0]     xmin_acc;
  logic [CW-1:0]     xmax_acc;
  logic [CW-1:0]     ymin_acc;
  logic [CW-1:0]     ymax_acc;

  always_comb begin
    total  = {32'd0, width} * {32'd0, height};
    bad    = (width == 32'd0) || (height == 32'd0) || (total > (64'd1 << MAP_AW));
    active = (state == S_SCAN) || (state == S_DRAIN);
    abort  = active && !map.dmn_end;
    hit    = active && map.dmn_end && pv[RD_LAT-1] && map.douta_dmn;
  end

  assign busy          = (state != S_IDLE);
  assign map.dmn_en    = en_r;
  assign map.addra_dmn = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      en_r      <= 1'b0;
      w_reg     <= '0;
      addr      <= '0;
      last_addr <= '0;
      xc        <= '0;
      yc        <= '0;
      drain_cnt <= '0;
      err_acc   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      found     <= 1'b0;
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
      pix_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            w_reg     <= width;
            last_addr <= MAP_AW'(total - 64'd1);
            err_acc   <= bad;
            if (bad) begin
              state <= S_DONE;
            end else begin
              en_r  <= 1'b1;
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (map.dmn_end) begin
            addr  <= '0;
            xc    <= '0;
            yc    <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort) begin
            err_acc <= 1'b1;
            en_r    <= 1'b0;
            state   <= S_REL;
          end else if (addr == last_addr) begin
            drain_cnt <= 3'(RD_LAT - 1);
            state     <= S_DRAIN;
          end else begin
            addr <= addr + 1'b1;
            if (32'(xc) == w_reg - 32'd1) begin
              xc <= '0;
              yc <= yc + 1'b1;
            end else begin
              xc <= xc + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            err_acc <= 1'b1;
            en_r    <= 1'b0;
            state   <= S_REL;
          end else if (drain_cnt == 3'd0) begin
            en_r  <= 1'b0;
            state <= S_REL;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_REL: begin
          if (!map.dmn_end) state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b1;
          err     <= err_acc;
          found   <= found_acc;
          pix_cnt <= pix_acc;
          x_min   <= found_acc ? xmin_acc : '0;
          x_max   <= found_acc ? xmax_acc : '0;
          y_min   <= found_acc ? ymin_acc : '0;
          y_max   <= found_acc ? ymax_acc : '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Coordinate tags travel alongside the outstanding reads so each returning
  // douta_dmn bit is matched to the (x,y) that requested it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        px[i] <= '0;
        py[i] <= '0;
      end
    end else if (abort) begin
      for (int i = 0; i < RD_LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= (state == S_SCAN);
      px[0] <= CW'(xc);
      py[0] <= CW'(yc);
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_acc <= 1'b0;
      pix_acc   <= '0;
      xmin_acc  <= '1;
      xmax_acc  <= '0;
      ymin_acc  <= '1;
      ymax_acc  <= '0;
    end else if (state == S_IDLE && start) begin
      found_acc <= 1'b0;
      pix_acc   <= '0;
      xmin_acc  <= '1;
      xmax_acc  <= '0;
      ymin_acc  <= '1;
      ymax_acc  <= '0;
    end else if (hit) begin
      found_acc <= 1'b1;
      pix_acc   <= pix_acc + 1'b1;
      if (px[RD_LAT-1] < xmin_acc) xmin_acc <= px[RD_LAT-1];
      if (px[RD_LAT-1] > xmax_acc) xmax_acc <= px[RD_LAT-1];
      if (py[RD_LAT-1] < ymin_acc) ymin_acc <= py[RD_LAT-1];
      if (py[RD_LAT-1] > ymax_acc) ymax_acc <= py[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_map_bbox_scan.sv
// Self-checking bench for map_bbox_scan: models the thresholding block's map
// memory and handshake, and compares each frame against a direct pixel sweep.
module tb_map_bbox_scan;
  localparam int MAP_AW = 16;
  localparam int CW     = 16;
  localparam int RD_LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     width = '0;
  logic [31:0]     height = '0;
  logic            busy, done, err, found;
  logic [CW-1:0]   x_min, x_max, y_min, y_max;
  logic [MAP_AW:0] pix_cnt;

  map_bbox_scan_if #(.MAP_AW(MAP_AW)) map_bus ();

  map_bbox_scan #(.MAP_AW(MAP_AW), .CW(CW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .map(map_bus), .busy(busy), .done(done), .err(err), .found(found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  bit   mem [0:65535];
  logic d_pipe [RD_LAT];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  // Synchronous map RAM with RD_LAT cycles from address to data.
  always @(posedge clk) begin
    d_pipe[0] <= mem[map_bus.addra_dmn];
    for (int i = 1; i < RD_LAT; i++) d_pipe[i] <= d_pipe[i-1];
  end
  assign map_bus.douta_dmn = d_pipe[RD_LAT-1];

  always @(negedge clk) if (!rst && done) done_cnt++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int abort_at,
                           input bit start_busy, input bit start_in_done);
    int total, ex_cnt, ex_xmin, ex_xmax, ex_ymin, ex_ymax, addr_bad, got, c0, x, y;
    bit aborted;
    total = w * h;
    ex_cnt = 0; ex_xmin = 0; ex_xmax = 0; ex_ymin = 0; ex_ymax = 0;
    for (int a = 0; a < total; a++) begin
      if (mem[a]) begin
        x = a % w;
        y = a / w;
        if (ex_cnt == 0) begin
          ex_xmin = x; ex_xmax = x; ex_ymin = y; ex_ymax = y;
        end else begin
          if (x < ex_xmin) ex_xmin = x;
          if (x > ex_xmax) ex_xmax = x;
          if (y < ex_ymin) ex_ymin = y;
          if (y > ex_ymax) ex_ymax = y;
        end
        ex_cnt++;
      end
    end
    c0 = done_cnt;
    aborted = 1'b0;
    addr_bad = 0;
    width = w; height = h; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("req_en", map_bus.dmn_en, 1);
    chk("req_busy", busy, 1);
    step($urandom_range(0, 3));
    map_bus.dmn_end = 1'b1;
    for (int i = 0; i < total; i++) begin
      start = start_busy && (i == 1);
      step(1);
      if (map_bus.addra_dmn != MAP_AW'(i)) addr_bad++;
      if (i == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("addr_seq", addr_bad, 0);
    if (aborted) begin
      map_bus.dmn_end = 1'b0;
      step(1);
      chk("abort_en_drop", map_bus.dmn_en, 0);
    end else begin
      step(RD_LAT);
      chk("en_hold", map_bus.dmn_en, 1);
      step(1);
      chk("en_rel", map_bus.dmn_en, 0);
      step($urandom_range(0, 3));
      map_bus.dmn_end = 1'b0;
      if (start_in_done) begin
        step(1);
        start = 1'b1;
      end
    end
    got = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      start = 1'b0;
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", got, 1);
    chk("err", err, aborted ? 1 : 0);
    if (!aborted) begin
      chk("found", found, (ex_cnt != 0) ? 1 : 0);
      chk("pix_cnt", pix_cnt, ex_cnt);
      chk("x_min", x_min, ex_xmin);
      chk("x_max", x_max, ex_xmax);
      chk("y_min", y_min, ex_ymin);
      chk("y_max", y_max, ex_ymax);
    end
    step(3);
    chk("done_once", done_cnt - c0, 1);
    chk("idle_after", busy, 0);
  endtask

  task automatic err_frame(input int w, input int h);
    int c0;
    c0 = done_cnt;
    width = w; height = h; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("errf_en0", map_bus.dmn_en, 0);
    step(1);
    chk("errf_done", done, 1);
    chk("errf_en1", map_bus.dmn_en, 0);
    chk("errf_err", err, 1);
    chk("errf_found", found, 0);
    chk("errf_pix", pix_cnt, 0);
    chk("errf_xmax", x_max, 0);
    step(2);
    chk("errf_once", done_cnt - c0, 1);
  endtask

  initial begin
    int w, h, dens;
    map_bus.dmn_end = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_found", found, 0);
    chk("rst_en", map_bus.dmn_en, 0);
    chk("rst_addr", map_bus.addra_dmn, 0);
    chk("rst_pix", pix_cnt, 0);
    chk("rst_xmin", x_min, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);

    clear_mem();
    mem[5] = 1'b1;
    run_frame(4, 3, -1, 1'b0, 1'b0);

    clear_mem();
    mem[1*8+2] = 1'b1;
    mem[1*8+6] = 1'b1;
    mem[7*8+3] = 1'b1;
    run_frame(8, 8, -1, 1'b1, 1'b0);

    clear_mem();
    run_frame(5, 5, -1, 1'b0, 1'b1);

    err_frame(0, 5);
    err_frame(300, 300);
    err_frame(7, 0);
    err_frame(65537, 1);

    mem[0] = 1'b1;
    run_frame(1, 1, -1, 1'b0, 1'b0);

    clear_mem();
    mem[1*8+2] = 1'b1;
    mem[1*8+6] = 1'b1;
    mem[7*8+3] = 1'b1;
    run_frame(8, 8, 20, 1'b0, 1'b0);
    run_frame(8, 8, -1, 1'b0, 1'b0);

    width = 8; height = 8; start = 1'b1;
    step(1);
    start = 1'b0;
    map_bus.dmn_end = 1'b1;
    step(4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", map_bus.dmn_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_found", found, 0);
    chk("mid_rst_pix", pix_cnt, 0);
    chk("mid_rst_xmax", x_max, 0);
    chk("mid_rst_ymax", y_max, 0);
    chk("mid_rst_addr", map_bus.addra_dmn, 0);
    map_bus.dmn_end = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);

    for (int f = 0; f < 8; f++) begin
      w = $urandom_range(1, 24);
      h = $urandom_range(1, 24);
      dens = $urandom_range(0, 3);
      clear_mem();
      for (int a = 0; a < w * h; a++)
        mem[a] = (dens != 0) && ($urandom_range(0, dens * 3) == 0);
      run_frame(w, h, -1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
